// File: rtl/multiport_array.sv
// Register array: one write port, read_ports async read ports, write-index preview, self-clearing sweep.
// Optional same-cycle write-to-read forwarding enabled by defining MULTIPORT_ARRAY_BYPASS_EN.
`timescale 1ns/1ps
module multiport_array #(
  parameter int unsigned width      = 16,
  parameter int unsigned height     = 32,
  parameter int unsigned read_ports = 2,
  localparam int unsigned IW        = $clog2(height)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         write,
  input  logic [IW-1:0]                index_in,
  input  logic [width-1:0]             datain,
  input  logic [read_ports*IW-1:0]     index_out,
  input  logic                         flush,
  output logic [read_ports*width-1:0]  dataout,
  output logic [width-1:0]             preview,
  output logic                         busy
);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_clr_ptr;
  logic [IW-1:0]     w_clr_ptr_nxt;
  logic [width-1:0]  r_mem [height];

  logic              w_mem_we;
  logic [IW-1:0]     w_mem_idx;
  logic [width-1:0]  w_mem_data;
  logic              w_wr_accept;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= S_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    w_mem_we      = 1'b0;
    w_mem_idx     = index_in;
    w_mem_data    = datain;
    case (r_state)
      S_CLEAR: begin
        w_mem_we   = 1'b1;
        w_mem_idx  = r_clr_ptr;
        w_mem_data = '0;
        if (r_clr_ptr == IW'(height - 1)) begin
          w_state_nxt   = S_IDLE;
          w_clr_ptr_nxt = '0;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + 1'b1;
        end
      end
      default: begin
        if (flush) begin
          w_state_nxt   = S_CLEAR;
          w_clr_ptr_nxt = '0;
        end else if (write) begin
          w_mem_we = 1'b1;
        end
      end
    endcase
  end

  // Storage has no reset; the sweep is what brings it to a known state.
  always_ff @(posedge clk) begin
    if (reset_n && w_mem_we) begin
      r_mem[w_mem_idx] <= w_mem_data;
    end
  end

  assign busy        = (r_state == S_CLEAR);
  assign w_wr_accept = reset_n && (r_state == S_IDLE) && write && !flush;

  always_comb begin
    dataout = '0;
    for (int unsigned p = 0; p < read_ports; p++) begin
      if (!busy) begin
`ifdef MULTIPORT_ARRAY_BYPASS_EN
        if (w_wr_accept && (index_out[p*IW +: IW] == index_in)) begin
          dataout[p*width +: width] = datain;
        end else begin
          dataout[p*width +: width] = r_mem[index_out[p*IW +: IW]];
        end
`else
        dataout[p*width +: width] = r_mem[index_out[p*IW +: IW]];
`endif
      end
    end
  end

  assign preview = busy ? '0 : r_mem[index_in];

`ifndef MULTIPORT_ARRAY_BYPASS_EN
  logic w_unused;
  assign w_unused = w_wr_accept;
`endif

endmodule

// File: tb/tb_multiport_array.sv
// Self-checking bench for multiport_array (height 32, width 16, four read ports) against a behavioural model.
`timescale 1ns/1ps
module tb_multiport_array;

  localparam int W  = 16;
  localparam int H  = 32;
  localparam int RP = 4;
  localparam int IW = 5;
`ifdef MULTIPORT_ARRAY_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              write;
  logic [IW-1:0]     index_in;
  logic [W-1:0]      datain;
  logic [RP*IW-1:0]  index_out;
  logic              flush;
  logic [RP*W-1:0]   dataout;
  logic [W-1:0]      preview;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] mdl [H];
  int           m_left;

  always #5 clk = ~clk;

  multiport_array #(.width(W), .height(H), .read_ports(RP)) dut (
    .clk(clk), .reset_n(reset_n), .write(write), .index_in(index_in),
    .datain(datain), .index_out(index_out), .flush(flush),
    .dataout(dataout), .preview(preview), .busy(busy)
  );

  // Model: a sweep is a countdown of H edges, after which the whole array is zero.
  task automatic model_edge();
    if (!reset_n) begin
      m_left = H;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) for (int i = 0; i < H; i++) mdl[i] = '0;
    end else if (flush) begin
      m_left = H;
    end else if (write) begin
      mdl[index_in] = datain;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [IW-1:0] idx);
    if (m_left > 0) return '0;
    if (BYP && reset_n && write && !flush && idx == index_in) return datain;
    return mdl[idx];
  endfunction

  function automatic logic [W-1:0] port(input int p);
    return dataout[p*W +: W];
  endfunction

  task automatic all_ports(input logic [IW-1:0] idx);
    for (int p = 0; p < RP; p++) index_out[p*IW +: IW] = idx;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; write = 1'b0; flush = 1'b0; index_in = '0; datain = '0; index_out = '0;
    m_left = H;
    step(); step();
    reset_n = 1'b1; #1;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_at_release got=%b exp=1", busy); end
    for (int k = 0; k < H; k++) begin
      step();
      n_tests++;
      if (busy !== (k < H - 1)) begin
        n_fail++; $display("FAIL reset_busy_edge%0d got=%b exp=%b", k, busy, (k < H - 1));
      end
      if (k < H - 1) begin
        n_tests++;
        if (dataout !== '0 || preview !== '0) begin
          n_fail++; $display("FAIL reset_out_zero edge%0d dataout=%h preview=%h exp=0", k, dataout, preview);
        end
      end
    end
    for (int i = 0; i < H; i++) begin
      all_ports(IW'(i)); #1;
      for (int p = 0; p < RP; p++) begin
        n_tests++;
        if (port(p) !== 16'h0000) begin
          n_fail++; $display("FAIL reset_entry%0d_port%0d got=%h exp=0000", i, p, port(p));
        end
      end
    end
  endtask

  task automatic test_write_read();
    write = 1'b1; index_in = 5'd5; datain = 16'hBEEF; step();
    n_tests++;
    if (preview !== 16'hBEEF) begin n_fail++; $display("FAIL preview_idx5 got=%h exp=beef", preview); end
    index_in = 5'd31; datain = 16'h1234; step();
    write = 1'b0;
    index_out = '0; index_out[0 +: IW] = 5'd5; index_out[IW +: IW] = 5'd31; #1;
    n_tests++;
    if (port(0) !== 16'hBEEF) begin n_fail++; $display("FAIL wr_rd_port0 got=%h exp=beef", port(0)); end
    n_tests++;
    if (port(1) !== 16'h1234) begin n_fail++; $display("FAIL wr_rd_port1 got=%h exp=1234", port(1)); end
    n_tests++;
    if (port(0) !== exp_rd(5'd5)) begin n_fail++; $display("FAIL wr_rd_model got=%h exp=%h", port(0), exp_rd(5'd5)); end
  endtask

  task automatic test_bypass();
    write = 1'b1; index_in = 5'd7; datain = 16'h0001; step();
    datain = 16'hAAAA; index_out[0 +: IW] = 5'd7; #1;
    n_tests++;
    if (port(0) !== (BYP ? 16'hAAAA : 16'h0001)) begin
      n_fail++; $display("FAIL bypass_same_cycle got=%h exp=%h", port(0), (BYP ? 16'hAAAA : 16'h0001));
    end
    n_tests++;
    if (preview !== 16'h0001) begin n_fail++; $display("FAIL bypass_preview got=%h exp=0001", preview); end
    step();
    write = 1'b0; #1;
    n_tests++;
    if (port(0) !== 16'hAAAA) begin n_fail++; $display("FAIL bypass_next_cycle got=%h exp=aaaa", port(0)); end
  endtask

  task automatic test_flush_collision();
    write = 1'b1; index_in = 5'd3; datain = 16'h00FF; step();
    datain = 16'h5555; flush = 1'b1; step();
    flush = 1'b0; write = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_busy_start got=%b exp=1", busy); end
    for (int k = 1; k <= H; k++) begin
      if (k == 5) flush = 1'b1;
      if (k == 6) begin flush = 1'b0; write = 1'b1; index_in = 5'd9; datain = 16'h1111; end
      if (k == 7) write = 1'b0;
      step();
      n_tests++;
      if (busy !== (k < H)) begin n_fail++; $display("FAIL flush_busy_edge%0d got=%b exp=%b", k, busy, (k < H)); end
    end
    all_ports(5'd3); #1;
    n_tests++;
    if (port(0) !== 16'h0000) begin n_fail++; $display("FAIL flush_entry3 got=%h exp=0000", port(0)); end
    all_ports(5'd9); #1;
    n_tests++;
    if (port(2) !== 16'h0000) begin n_fail++; $display("FAIL flush_busy_write_ignored got=%h exp=0000", port(2)); end
    write = 1'b1; index_in = 5'd3; datain = 16'h7777; step();
    write = 1'b0; all_ports(5'd3); #1;
    n_tests++;
    if (port(1) !== 16'h7777) begin n_fail++; $display("FAIL flush_first_write got=%h exp=7777", port(1)); end
  endtask

  task automatic test_reset_mid_sweep();
    flush = 1'b1; step();
    flush = 1'b0;
    for (int k = 1; k <= 10; k++) step();
    reset_n = 1'b0; write = 1'b1; index_in = 5'd2; datain = 16'hDEAD; step();
    reset_n = 1'b1; write = 1'b0; all_ports(5'd2); #1;
    for (int k = 0; k < H; k++) begin
      step();
      n_tests++;
      if (busy !== (k < H - 1)) begin n_fail++; $display("FAIL mid_busy_edge%0d got=%b exp=%b", k, busy, (k < H - 1)); end
      n_tests++;
      if (dataout !== '0) begin n_fail++; $display("FAIL mid_dataout edge%0d got=%h exp=0", k, dataout); end
    end
  endtask

  task automatic test_multiport();
    write = 1'b1; index_in = 5'd12; datain = 16'h0C0C; step();
    write = 1'b0; all_ports(5'd12); #1;
    for (int p = 0; p < RP; p++) begin
      n_tests++;
      if (port(p) !== 16'h0C0C) begin n_fail++; $display("FAIL multiport_p%0d got=%h exp=0c0c", p, port(p)); end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 400; c++) begin
      write    = 1'($urandom_range(0, 1));
      flush    = ($urandom_range(0, 59) == 0);
      index_in = IW'($urandom);
      datain   = W'($urandom);
      for (int p = 0; p < RP; p++) index_out[p*IW +: IW] = IW'($urandom);
      #1;
      n_tests++;
      if (busy !== (m_left > 0)) begin n_fail++; $display("FAIL rnd_busy c%0d got=%b exp=%b", c, busy, (m_left > 0)); end
      n_tests++;
      if (preview !== ((m_left > 0) ? 16'h0000 : mdl[index_in])) begin
        n_fail++; $display("FAIL rnd_preview c%0d got=%h exp=%h", c, preview, ((m_left > 0) ? 16'h0000 : mdl[index_in]));
      end
      for (int p = 0; p < RP; p++) begin
        n_tests++;
        if (port(p) !== exp_rd(index_out[p*IW +: IW])) begin
          n_fail++; $display("FAIL rnd_port%0d c%0d got=%h exp=%h", p, c, port(p), exp_rd(index_out[p*IW +: IW]));
        end
      end
      step();
    end
    write = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_flush_collision();
    test_reset_mid_sweep();
    test_multiport();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
